// File: rtl/cmd_pulse_tx.sv
// Transmit-side command pulse shaper: turns single-cycle requests into fixed-width
// line pulses separated by a guaranteed low gap, queueing requests that arrive early.
module cmd_pulse_tx #(
  parameter int PULSE_WIDTH = 3,
  parameter int GAP_WIDTH   = 3,
  parameter int PEND_WIDTH  = 2
) (
  input  logic                  clk,
  input  logic                  aclr,
  input  logic                  req,
  output logic                  out,
  output logic                  busy,
  output logic [PEND_WIDTH-1:0] pend,
  output logic                  ovf
);

  localparam int CNT_MAX = ((PULSE_WIDTH > GAP_WIDTH) ? PULSE_WIDTH : GAP_WIDTH) - 1;
  localparam int CW      = (CNT_MAX < 1) ? 1 : $clog2(CNT_MAX + 1);

  localparam logic [CW-1:0]         PULSE_LOAD = CW'(PULSE_WIDTH - 1);
  localparam logic [CW-1:0]         GAP_LOAD   = CW'(GAP_WIDTH - 1);
  localparam logic [CW-1:0]         CNT_ZERO   = '0;
  localparam logic [CW-1:0]         CNT_ONE    = CW'(1);
  localparam logic [PEND_WIDTH-1:0] PEND_ZERO  = '0;
  localparam logic [PEND_WIDTH-1:0] PEND_ONE   = PEND_WIDTH'(1);
  localparam logic [PEND_WIDTH-1:0] PEND_MAX   = '1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HIGH = 2'd1,
    GAP  = 2'd2
  } state_t;

  state_t                  state_reg, state_next;
  logic [CW-1:0]           cnt_reg, cnt_next;
  logic [PEND_WIDTH-1:0]   pend_reg, pend_next;
  logic                    ovf_reg, ovf_next;
  logic                    out_reg, busy_reg;
  logic                    cnt_done;

  assign cnt_done = (cnt_reg == CNT_ZERO);

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    pend_next  = pend_reg;
    ovf_next   = ovf_reg;

    case (state_reg)
      IDLE: begin
        if (req) begin
          state_next = HIGH;
          cnt_next   = PULSE_LOAD;
        end
      end

      HIGH: begin
        if (!cnt_done) begin
          cnt_next = cnt_reg - CNT_ONE;
        end else begin
          state_next = GAP;
          cnt_next   = GAP_LOAD;
        end
        if (req) begin
          if (pend_reg != PEND_MAX) pend_next = pend_reg + PEND_ONE;
          else                      ovf_next  = 1'b1;
        end
      end

      GAP: begin
        if (!cnt_done) begin
          cnt_next = cnt_reg - CNT_ONE;
          if (req) begin
            if (pend_reg != PEND_MAX) pend_next = pend_reg + PEND_ONE;
            else                      ovf_next  = 1'b1;
          end
        end else if (pend_reg != PEND_ZERO) begin
          // Gap end with work queued: a coincident req replaces the one consumed.
          state_next = HIGH;
          cnt_next   = PULSE_LOAD;
          if (!req) pend_next = pend_reg - PEND_ONE;
        end else if (req) begin
          state_next = HIGH;
          cnt_next   = PULSE_LOAD;
        end else begin
          state_next = IDLE;
        end
      end

      default: begin
        state_next = IDLE;
        cnt_next   = CNT_ZERO;
        pend_next  = PEND_ZERO;
      end
    endcase
  end

  // Line outputs get their own flops loaded from the next state, so they are
  // glitch-free and have no combinational path from req.
  always_ff @(posedge clk) begin
    if (aclr) begin
      state_reg <= IDLE;
      cnt_reg   <= CNT_ZERO;
      pend_reg  <= PEND_ZERO;
      ovf_reg   <= 1'b0;
      out_reg   <= 1'b0;
      busy_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      pend_reg  <= pend_next;
      ovf_reg   <= ovf_next;
      out_reg   <= (state_next == HIGH);
      busy_reg  <= (state_next != IDLE);
    end
  end

  assign out  = out_reg;
  assign busy = busy_reg;
  assign pend = pend_reg;
  assign ovf  = ovf_reg;

endmodule

// File: tb/tb_cmd_pulse_tx.sv
// Directed bench for cmd_pulse_tx: per-cycle stimulus and hand-derived expected
// waveforms for each scenario, with cycle c meaning the interval ending at edge c.
module tb_cmd_pulse_tx;

  logic       clk = 1'b0;
  logic       aclr;
  logic       req;
  logic       out;
  logic       busy;
  logic [1:0] pend;
  logic       ovf;

  int n_checks = 0;
  int n_fail   = 0;

  cmd_pulse_tx #(
    .PULSE_WIDTH(3),
    .GAP_WIDTH  (3),
    .PEND_WIDTH (2)
  ) dut (
    .clk (clk),
    .aclr(aclr),
    .req (req),
    .out (out),
    .busy(busy),
    .pend(pend),
    .ovf (ovf)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic bit in_rng(input int c, input int lo, input int hi);
    return (c >= lo) && (c <= hi);
  endfunction

  // Scenarios: 0 single, 1 burst, 2 overflow, 3 gap-end coincidence,
  // 4 reset mid-operation, 5 gap-end with full queue.
  function automatic bit req_at(input int sc, input int c);
    case (sc)
      0: return c == 10;
      1: return in_rng(c, 10, 12);
      2: return in_rng(c, 10, 14);
      3: return (c == 10) || (c == 16);
      4: return in_rng(c, 10, 12) || (c == 14);
      5: return in_rng(c, 10, 13) || (c == 16);
      default: return 1'b0;
    endcase
  endfunction

  function automatic bit aclr_at(input int sc, input int c);
    return (c == 0) || (sc == 4 && c == 12);
  endfunction

  function automatic int exp_out(input int sc, input int c);
    case (sc)
      0: return int'(in_rng(c, 11, 13));
      1: return int'(in_rng(c, 11, 13) || in_rng(c, 17, 19) || in_rng(c, 23, 25));
      2: return int'(in_rng(c, 11, 13) || in_rng(c, 17, 19) || in_rng(c, 23, 25)
                     || in_rng(c, 29, 31));
      3: return int'(in_rng(c, 11, 13) || in_rng(c, 17, 19));
      4: return int'(in_rng(c, 11, 12) || in_rng(c, 15, 17));
      5: return int'(in_rng(c, 11, 13) || in_rng(c, 17, 19) || in_rng(c, 23, 25)
                     || in_rng(c, 29, 31) || in_rng(c, 35, 37));
      default: return 0;
    endcase
  endfunction

  function automatic int exp_busy(input int sc, input int c);
    case (sc)
      0: return int'(in_rng(c, 11, 16));
      1: return int'(in_rng(c, 11, 28));
      2: return int'(in_rng(c, 11, 34));
      3: return int'(in_rng(c, 11, 22));
      4: return int'(in_rng(c, 11, 12) || in_rng(c, 15, 20));
      5: return int'(in_rng(c, 11, 40));
      default: return 0;
    endcase
  endfunction

  function automatic int exp_pend(input int sc, input int c);
    case (sc)
      1: begin
        if (c == 12) return 1;
        if (in_rng(c, 13, 16)) return 2;
        if (in_rng(c, 17, 22)) return 1;
        return 0;
      end
      2: begin
        if (c == 12) return 1;
        if (c == 13) return 2;
        if (in_rng(c, 14, 16)) return 3;
        if (in_rng(c, 17, 22)) return 2;
        if (in_rng(c, 23, 28)) return 1;
        return 0;
      end
      4: return int'(c == 12);
      5: begin
        if (c == 12) return 1;
        if (c == 13) return 2;
        if (in_rng(c, 14, 22)) return 3;
        if (in_rng(c, 23, 28)) return 2;
        if (in_rng(c, 29, 34)) return 1;
        return 0;
      end
      default: return 0;
    endcase
  endfunction

  function automatic int exp_ovf(input int sc, input int c);
    return int'(sc == 2 && c >= 15);
  endfunction

  function automatic int last_cycle(input int sc);
    case (sc)
      0: return 20;
      1: return 32;
      2: return 40;
      3: return 26;
      4: return 24;
      default: return 44;
    endcase
  endfunction

  task automatic run_scenario(input int sc);
    aclr = aclr_at(sc, 0);
    req  = req_at(sc, 0);
    for (int c = 1; c <= last_cycle(sc); c++) begin
      @(posedge clk);
      #1;
      aclr = aclr_at(sc, c);
      req  = req_at(sc, c);
      check_eq($sformatf("s%0d c%0d out", sc, c),  int'(out),  exp_out(sc, c));
      check_eq($sformatf("s%0d c%0d busy", sc, c), int'(busy), exp_busy(sc, c));
      check_eq($sformatf("s%0d c%0d pend", sc, c), int'(pend), exp_pend(sc, c));
      check_eq($sformatf("s%0d c%0d ovf", sc, c),  int'(ovf),  exp_ovf(sc, c));
    end
    $display("scenario %0d done: %0d checks so far, %0d failures", sc, n_checks, n_fail);
    @(posedge clk);
    #1;
  endtask

  initial begin
    aclr = 1'b1;
    req  = 1'b0;
    @(posedge clk);
    #1;
    for (int sc = 0; sc < 6; sc++) begin
      run_scenario(sc);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/cmd_pulse_tx.md
# cmd_pulse_tx

Transmit-side command pulse shaper: converts single-cycle command requests into line pulses of fixed width separated by a guaranteed minimum low gap. Requests arriving while a pulse or gap is in progress are queued in a saturating pending counter. Overflow is flagged sticky. The block sits at the command output pins, opposite the receive-side input filter. GAP_WIDTH is chosen larger than the far-end filter hold time (2^FILTER_WIDTH − 1 cycles), so consecutive pulses are never merged at the receiver.

## Interface
- PULSE_WIDTH, default 3: line high time in clk cycles; ≥1.
- GAP_WIDTH, default 3: minimum line low time between pulses in clk cycles; ≥1.
- PEND_WIDTH, default 2: pending counter width; maximum queued requests = 2^PEND_WIDTH − 1.
- clk  input  1  clock; all logic on rising edge.
- aclr  input  1  reset: synchronous, active-high, takes priority over all other inputs.
- req  input  1  command request, one pulse per high cycle; sampled every edge.
- out  output  1  command line; registered.
- busy  output  1  high while state ≠ IDLE; registered.
- pend  output  PEND_WIDTH  number of queued requests; registered.
- ovf  output  1  sticky overflow (a request was dropped); cleared only by aclr.

## Operation
- States: IDLE (out=0), HIGH (out=1), GAP (out=0). Down-counter cnt is sized for max(PULSE_WIDTH, GAP_WIDTH) − 1.
- Reset (aclr=1 at an edge): state IDLE, cnt=0, out=0, busy=0, pend=0, ovf=0. req is ignored in that cycle. Reset mid-pulse or mid-gap aborts the pulse or gap and discards the queue.
- IDLE: pend is always 0. If req=1 → HIGH with cnt=PULSE_WIDTH−1; otherwise stay.
- HIGH: if cnt≠0, cnt−1. If cnt=0 → GAP with cnt=GAP_WIDTH−1.
- GAP, cnt≠0: cnt−1.
- GAP, cnt=0 (gap end):
  - pend>0 → HIGH, with pend_next = pend − 1 + req.
  - pend=0 and req=1 → HIGH, pend stays 0.
  - Otherwise → IDLE.
- req in HIGH, or in GAP with cnt≠0:
  - If pend < max, pend+1.
  - If pend = max, the request is dropped and ovf is set to 1.
- req at gap end with pend=max: one request is consumed and one added, so pend stays at max and no overflow occurs.
- pend never wraps. ovf never clears except on aclr.
- out = (state==HIGH), busy = (state≠IDLE). Both are taken from the state register, with no combinational path from req.

## Timing
- Latency: req sampled at edge t in IDLE → out high for cycles t+1 … t+PULSE_WIDTH.
- The line is then low for cycles t+PULSE_WIDTH+1 … t+PULSE_WIDTH+GAP_WIDTH.
- Back-to-back pulses repeat with period PULSE_WIDTH+GAP_WIDTH. The low time between pulses is exactly GAP_WIDTH, never less.
- busy rises with out (cycle t+1). It falls the cycle after the last gap cycle if nothing is pending.
- pend and ovf update at the same edge that samples req; the new value is visible the following cycle.
- Outputs after reset: out=0, busy=0, pend=0, ovf=0 from the cycle after the aclr edge.
- With PULSE_WIDTH=1 or GAP_WIDTH=1, the corresponding state lasts exactly one cycle (cnt loads 0).

## Test plan
All scenarios use PULSE_WIDTH=3, GAP_WIDTH=3, PEND_WIDTH=2; cycle numbers are edge indices.
- **Single request:** req at cycle 10 only → out=1 in cycles 11–13 and 0 in 14–16; busy=1 in cycles 11–16 and 0 from 17; pend=0 and ovf=0 throughout.
- **Queued burst:** req at cycles 10, 11, 12 → pend=1 at cycle 12 and 2 at 13; pulses in cycles 11–13, 17–19 and 23–25; pend=1 at 17, 0 at 23; busy falls at cycle 29.
- **Overflow:** req held high for cycles 10–14, then low:
  - pend reaches 3 at cycle 14.
  - The request in cycle 14 is dropped, so ovf=1 from cycle 15 and stays 1.
  - Exactly 4 pulses are emitted, starting at cycles 11, 17, 23 and 29.
- **Gap-end coincidence:** req at cycles 10 and 16 → second pulse in cycles 17–19; pend stays 0; ovf=0.
- **Reset mid-operation:** req at cycles 10 and 11, aclr=1 at cycle 12 with req=1 → from cycle 13 out=0, busy=0, pend=0, ovf=0; no further pulse. A new req at cycle 14 → pulse in cycles 15–17.
